alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle fetch/decode/issue controller; the initiator side of the existing combinational ALU interface.
- Fetches 32-bit instruction words over a valid/request handshake and decodes them.
- Reads operands from an internal 8x32 register file and drives the ALU operand, opcode and addressing-mode inputs.
- Captures the ALU result and 4-bit compare vector, writes back, and executes conditional branches from a latched flags register.

Parameters:
PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W
NREG, 8, register file depth (fixed by the 3-bit register fields; do not change)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or HALTED
imem_req  out  1  fetch request; held high until imem_valid
imem_addr  out  PC_W  fetch address (= PC)
imem_valid  in  1  instruction word valid; sampled only while imem_req=1
imem_data  in  32  instruction word
alu_reg_a_data  out  32  ALU operand A (register ra)
alu_reg_b_data  out  32  ALU operand B (register rb)
alu_immediate  out  21  instruction bits [20:0]
alu_opcode  out  4  ALU opcode
alu_addressing_mode  out  1  1 = register operand B, 0 = zero-extended immediate
alu_result  in  32  ALU result
alu_cmp_result  in  4  {gt, lt, ne, eq}, unsigned
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALTED
illegal  out  1  sticky; set by an illegal opcode
pc  out  PC_W  current PC
dbg_addr  in  3  debug register-file read address
dbg_data  out  32  combinational read of register dbg_addr

Behaviour:
- Reset:
  - All outputs, PC, instruction register, flags and all registers go to 0; state becomes IDLE.
  - A mid-fetch reset drops imem_req immediately.
- Instruction word layout:
  - [31:28] opcode, [27] am, [26:24] rd/cond, [23:21] ra, [20:0] imm.
  - rb = imm[2:0] when am=1.
- Opcodes:
  - ALU ops: ADD 0010, SUB 0011, MOV 0100, AND 1000, ORR 1001, EOR 1010, MVN 1011, LSL 1100, LSR 1101.
  - Controller-only ops: HALT 0000, CMP 0001, B 0110, NOP 0111.
  - Illegal: 0101, 1110, 1111.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE/HALTED: start sets PC=0, clears halted and illegal, and moves to FETCH. start in any other state is ignored.
  - FETCH: imem_req=1 and imem_addr=PC. On imem_valid=1, latch imem_data and go to DECODE. Zero-wait minimum is 1 cycle.
  - DECODE (1 cycle): register operands ra/rb into operand registers.
    - HALT -> HALTED.
    - Illegal -> illegal=1 and HALTED.
    - Otherwise -> EXEC.
  - EXEC (1 cycle): ALU outputs are stable from registers.
    - ALU ops: capture alu_result.
    - CMP: drive alu_opcode=SUB and latch alu_cmp_result into flags.
    - Go to WB.
  - WB (1 cycle):
    - ALU ops write rd.
    - B: PC <= imm[PC_W-1:0] if the condition holds, else PC+1.
    - All other ops: PC <= PC+1 (mod 2^PC_W).
    - Go to FETCH.
- Latency: an instruction with a zero-wait fetch takes 4 cycles.
- Branch conditions (rd field): 000 always, 001 EQ, 010 NE, 011 LT, 100 GT (flags from the last CMP); 101-111 never taken.
- alu_opcode holds the instruction opcode, except CMP, which drives SUB. alu_immediate and alu_addressing_mode come from the instruction register and are 0 after reset.
- Flags are modified only by CMP; they persist across other instructions and reset to 0.
- The register file has no hardwired zero; rd=ra is legal because reads complete in DECODE, before the WB write.
- PC wrap: from 2^PC_W-1, PC+1 gives 0.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams (shared values with the ALU);
  - the state enum;
  - branch condition codes;
  - instruction field bit positions.
- Sub-module alu_issue_regfile: 8x32, two async read ports + debug read port, one sync write port, async reset to 0.

Test Plan:
- MOV r1,#5 (am=0); ADD r2,r1,#3 → after the WB cycles, dbg r1=5, r2=8; each instruction takes 4 cycles with zero-wait imem.
- imem_valid delayed 3 cycles → imem_req stays high and imem_addr stays stable the whole time; the instruction completes 3 cycles later.
- CMP r1(5),#5 then B EQ to 0x20 → flags=0001 and PC=0x20. With CMP #9 instead → flags=0110 (lt, ne) and PC advances by +1.
- Opcode 1110 → illegal=1, halted=1, busy=0; a later start → illegal=0 and fetch resumes at PC=0.
- Assert rst during FETCH and during EXEC → imem_req=0 immediately, state is IDLE, and all registers read 0.
- PC=0xFF executing NOP → next fetch from address 0x00; LSR r3,r1,#1 with r1=5 → r3=2.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, FSM states,
// branch conditions and instruction field positions.
package alu_issue_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_CMP  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_B    = 4'b0110;
  localparam logic [3:0] OP_NOP  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_ORR  = 4'b1001;
  localparam logic [3:0] OP_EOR  = 4'b1010;
  localparam logic [3:0] OP_MVN  = 4'b1011;
  localparam logic [3:0] OP_LSL  = 4'b1100;
  localparam logic [3:0] OP_LSR  = 4'b1101;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GT = 3'd4;

  // flag vector is {gt, lt, ne, eq}
  localparam int FLG_EQ = 0;
  localparam int FLG_NE = 1;
  localparam int FLG_LT = 2;
  localparam int FLG_GT = 3;

  localparam int F_OPC_HI = 31;
  localparam int F_OPC_LO = 28;
  localparam int F_AM     = 27;
  localparam int F_RD_HI  = 26;
  localparam int F_RD_LO  = 24;
  localparam int F_RA_HI  = 23;
  localparam int F_RA_LO  = 21;
  localparam int F_IMM_HI = 20;
  localparam int F_RB_HI  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_ORR,
      OP_EOR, OP_MVN, OP_LSL, OP_LSR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] flags);
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return flags[FLG_EQ];
      COND_NE: return flags[FLG_NE];
      COND_LT: return flags[FLG_LT];
      COND_GT: return flags[FLG_GT];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x32 register file: two async read ports, a debug read port and one
// synchronous write port; every entry clears on reset.
module alu_issue_regfile #(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   ra_data,
  output logic [31:0]   rb_data,
  output logic [31:0]   dbg_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [NREG-1:0][31:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Fetch/decode/issue controller driving a combinational ALU; writes results
// back and resolves conditional branches from flags latched by CMP.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [31:0]     alu_reg_a_data,
  output logic [31:0]     alu_reg_b_data,
  output logic [20:0]     alu_immediate,
  output logic [3:0]      alu_opcode,
  output logic            alu_addressing_mode,
  input  logic [31:0]     alu_result,
  input  logic [3:0]      alu_cmp_result,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [PC_W-1:0] pc,
  input  logic [2:0]      dbg_addr,
  output logic [31:0]     dbg_data
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir, op_a, op_b, res;
  logic [3:0]      flags;
  logic            illegal_q;

  logic [3:0]  opc;
  logic [2:0]  rd, ra, rb;
  logic [20:0] imm;
  logic [31:0] ra_data, rb_data;
  logic        rf_we;

  assign opc = ir[F_OPC_HI:F_OPC_LO];
  assign rd  = ir[F_RD_HI:F_RD_LO];
  assign ra  = ir[F_RA_HI:F_RA_LO];
  assign rb  = ir[F_RB_HI:0];
  assign imm = ir[F_IMM_HI:0];

  assign rf_we = (state == S_WB) && is_alu_op(opc);

  alu_issue_regfile #(.NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (ra),
    .rb_addr  (rb),
    .dbg_addr (dbg_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALTED: if (start) state_nx = S_FETCH;
      S_FETCH:          if (imem_valid) state_nx = S_DECODE;
      S_DECODE:         state_nx = (opc == OP_HALT || is_illegal_op(opc)) ? S_HALTED : S_EXEC;
      S_EXEC:           state_nx = S_WB;
      S_WB:             state_nx = S_FETCH;
      default:          state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      flags     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: if (start) begin
          pc_q      <= '0;
          illegal_q <= 1'b0;
        end
        S_FETCH: if (imem_valid) ir <= imem_data;
        S_DECODE: begin
          op_a <= ra_data;
          op_b <= rb_data;
          if (is_illegal_op(opc)) illegal_q <= 1'b1;
        end
        S_EXEC: begin
          if (is_alu_op(opc)) res   <= alu_result;
          if (opc == OP_CMP)  flags <= alu_cmp_result;
        end
        S_WB: begin
          if (opc == OP_B && cond_taken(rd, flags)) pc_q <= imm[PC_W-1:0];
          else                                      pc_q <= pc_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operands stay in registers so the ALU sees stable inputs through EXEC.
  assign alu_reg_a_data      = op_a;
  assign alu_reg_b_data      = op_b;
  assign alu_immediate       = imm;
  assign alu_addressing_mode = ir[F_AM];
  assign alu_opcode          = (opc == OP_CMP) ? OP_SUB : opc;

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign halted    = (state == S_HALTED);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench: an instruction memory responder runs an architectural
// model per delivered word; a monitor checks each new fetch and each halt.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int PC_W = 8;

  logic            clk, rst, start;
  logic            imem_req, imem_valid;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     imem_data;
  logic [31:0]     alu_reg_a_data, alu_reg_b_data, alu_result, alu_b;
  logic [20:0]     alu_immediate;
  logic [3:0]      alu_opcode, alu_cmp_result;
  logic            alu_addressing_mode, busy, halted, illegal;
  logic [2:0]      dbg_addr, dbg_mon, dbg_main;
  logic            main_dbg;
  logic [31:0]     dbg_data;

  assign dbg_addr = main_dbg ? dbg_main : dbg_mon;

  alu_issue_ctrl #(.PC_W(PC_W), .NREG(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_reg_a_data(alu_reg_a_data), .alu_reg_b_data(alu_reg_b_data),
    .alu_immediate(alu_immediate), .alu_opcode(alu_opcode),
    .alu_addressing_mode(alu_addressing_mode),
    .alu_result(alu_result), .alu_cmp_result(alu_cmp_result),
    .busy(busy), .halted(halted), .illegal(illegal), .pc(pc),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MOV:  return b;
      OP_AND:  return a & b;
      OP_ORR:  return a | b;
      OP_EOR:  return a ^ b;
      OP_MVN:  return ~b;
      OP_LSL:  return a << b[4:0];
      OP_LSR:  return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // The external ALU: compare outputs only come from a subtract.
  always_comb begin
    alu_b          = alu_addressing_mode ? alu_reg_b_data : {11'b0, alu_immediate};
    alu_result     = alu_fn(alu_opcode, alu_reg_a_data, alu_b);
    alu_cmp_result = 4'b0;
    if (alu_opcode == OP_SUB)
      alu_cmp_result = {alu_reg_a_data > alu_b, alu_reg_a_data < alu_b,
                        alu_reg_a_data != alu_b, alu_reg_a_data == alu_b};
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic am, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [20:0] imm);
    return {op, am, rd, ra, imm};
  endfunction

  // kind: 0 start, 1 executed instruction, 2 halt, 3 illegal
  typedef struct {
    int         kind;
    logic [7:0] pc;
    bit         wr;
    logic [2:0] rd;
    logic [31:0] val;
    int         gap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_reg [8];
  logic [3:0]  m_flags;
  logic [7:0]  m_pc;
  logic [31:0] prog [256];
  int          fixed_delay, budget, deliveries;
  bit          hold;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_flags = 4'h0;
    m_pc    = 8'h0;
    sb.delete();
  endtask

  task automatic model_exec(input logic [31:0] w, input int waited);
    exp_t        e;
    logic [3:0]  op;
    logic [2:0]  rd, ra;
    logic [20:0] imm;
    logic [31:0] a, b, v;
    bit          taken;
    op = w[31:28]; rd = w[26:24]; ra = w[23:21]; imm = w[20:0];
    a = m_reg[ra];
    b = w[27] ? m_reg[imm[2:0]] : {11'b0, imm};
    e.kind = 1; e.wr = 0; e.rd = rd; e.val = 0; e.gap = waited + 4;
    if (op == OP_HALT) e.kind = 2;
    else if (op == 4'b0101 || op == 4'b1110 || op == 4'b1111) e.kind = 3;
    else if (op == OP_CMP) begin
      m_flags = {a > b, a < b, a != b, a == b};
      m_pc++;
    end else if (op == OP_B) begin
      case (rd)
        3'd0:    taken = 1;
        3'd1:    taken = m_flags[0];
        3'd2:    taken = m_flags[1];
        3'd3:    taken = m_flags[2];
        3'd4:    taken = m_flags[3];
        default: taken = 0;
      endcase
      m_pc = taken ? imm[7:0] : m_pc + 8'd1;
    end else if (op == OP_NOP) m_pc++;
    else begin
      v = alu_fn(op, a, b);
      m_reg[rd] = v;
      e.wr = 1; e.val = v;
      m_pc++;
    end
    e.pc = m_pc;
    sb.push_back(e);
  endtask

  // Instruction memory: answers each fetch after a programmable delay.
  initial begin
    int         cnt, waited;
    logic [7:0] wait_addr;
    logic [31:0] w;
    cnt = -1; waited = 0; wait_addr = 0;
    imem_valid = 1'b0; imem_data = 32'h0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (rst || !imem_req) cnt = -1;
      else begin
        if (cnt < 0) begin
          cnt       = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(2, 0));
          waited    = 0;
          wait_addr = imem_addr;
        end else check("addr_stable", imem_addr, wait_addr);
        if (cnt == 0 && !hold) begin
          w = (budget == 0) ? 32'h0 : prog[imem_addr];
          if (budget > 0) budget--;
          imem_data  = w;
          imem_valid = 1'b1;
          deliveries++;
          model_exec(w, waited);
          cnt = -1;
        end else begin
          if (cnt > 0) cnt--;
          waited++;
        end
      end
    end
  end

  // Monitor: every new fetch retires one expected entry, as does every halt.
  initial begin
    bit   prev_req, prev_halt;
    int   cyc, last;
    exp_t e;
    prev_req = 0; prev_halt = 0; cyc = 0; last = 0; dbg_mon = 3'd0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        prev_req = 0; prev_halt = 0;
        continue;
      end
      if (imem_req && !prev_req) begin
        if (sb.size() == 0) check("sb_empty_at_fetch", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("fetch_kind", 32'(e.kind <= 1), 32'd1);
          check("fetch_addr", imem_addr, e.pc);
          check("pc_out", pc, e.pc);
          check("illegal_clear", illegal, 0);
          check("busy_fetch", busy, 1);
          if (e.kind == 1) check("latency", cyc - last, e.gap);
          if (e.wr) begin
            dbg_mon = e.rd;
            #1;
            check("wb_value", dbg_data, e.val);
          end
        end
        last = cyc;
      end
      if (halted && !prev_halt) begin
        if (sb.size() == 0) check("sb_empty_at_halt", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("halt_kind", 32'(e.kind >= 2), 32'd1);
          check("illegal_flag", illegal, 32'(e.kind == 3));
          check("busy_halt", busy, 0);
        end
      end
      prev_req  = imem_req;
      prev_halt = halted;
    end
  end

  task automatic pulse_start();
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    m_pc  = 8'h0;
    e.kind = 0; e.pc = 8'h0; e.wr = 0; e.rd = 0; e.val = 0; e.gap = 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_prog();
    pulse_start();
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check("halt_reached", halted, 1);
    @(negedge clk);
    #4;
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_regs_zero(input string tag);
    main_dbg = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dbg_main = 3'(i);
      #1;
      check(tag, dbg_data, 0);
    end
    main_dbg = 1'b0;
  endtask

  task automatic check_reg(input logic [2:0] r, input logic [31:0] v);
    main_dbg = 1'b1;
    dbg_main = r;
    #1;
    check("final_reg", dbg_data, v);
    main_dbg = 1'b0;
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    check("rst_req_drop", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check_regs_zero("rst_regs");
    model_reset();
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] legal_ops [12];

  initial begin
    int d0;
    legal_ops = '{OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_ORR, OP_EOR,
                  OP_MVN, OP_LSL, OP_LSR, OP_CMP, OP_B, OP_NOP};
    rst = 1'b1; start = 1'b0; hold = 1'b0; fixed_delay = 0; budget = 0; deliveries = 0;
    main_dbg = 1'b0; dbg_main = 3'd0;
    model_reset();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    repeat (2) @(negedge clk);

    check("reset_req", imem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_halted", halted, 0);
    check("reset_illegal", illegal, 0);
    check("reset_pc", pc, 0);
    check("reset_opcode", alu_opcode, 0);
    check("reset_imm", alu_immediate, 0);
    check("reset_am", alu_addressing_mode, 0);
    check("reset_opa", alu_reg_a_data, 0);
    check_regs_zero("reset_regs");
    @(negedge clk);
    rst = 1'b0;

    prog[8'h00] = mk(OP_MOV, 0, 3'd1, 3'd0, 21'd5);
    prog[8'h01] = mk(OP_ADD, 0, 3'd2, 3'd1, 21'd3);
    prog[8'h02] = mk(OP_CMP, 0, 3'd0, 3'd1, 21'd5);
    prog[8'h03] = mk(OP_B,   0, COND_EQ, 3'd0, 21'h20);
    prog[8'h20] = mk(OP_CMP, 0, 3'd0, 3'd1, 21'd9);
    prog[8'h21] = mk(OP_B,   0, COND_EQ, 3'd0, 21'h40);
    prog[8'h22] = mk(OP_LSR, 0, 3'd3, 3'd1, 21'd1);
    prog[8'h23] = mk(OP_B,   0, COND_LT, 3'd0, 21'h30);
    prog[8'h30] = mk(OP_EOR, 1, 3'd4, 3'd2, 21'd1);
    prog[8'h31] = 32'h0;

    budget = 100; fixed_delay = 0;
    run_prog();
    check_reg(3'd1, 32'd5);
    check_reg(3'd2, 32'd8);
    check_reg(3'd3, 32'd2);
    check_reg(3'd4, 32'd13);
    check("halt_pc", pc, 8'h31);

    budget = 100; fixed_delay = 3;
    run_prog();

    prog[8'h00] = {4'b1110, 28'h0};
    budget = 100; fixed_delay = 0;
    run_prog();
    check("illegal_set", illegal, 1);
    check("illegal_halted", halted, 1);
    check("illegal_busy", busy, 0);
    prog[8'h00] = mk(OP_MOV, 0, 3'd1, 3'd0, 21'd5);
    budget = 100;
    run_prog();
    check("restart_illegal", illegal, 0);

    prog[8'h00] = mk(OP_B, 0, COND_AL, 3'd0, 21'hFF);
    prog[8'hFF] = mk(OP_NOP, 0, 3'd0, 3'd0, 21'd0);
    budget = 2;
    run_prog();
    prog[8'h00] = mk(OP_MOV, 0, 3'd1, 3'd0, 21'd5);
    prog[8'hFF] = 32'h0;

    hold = 1'b1; budget = 100;
    pulse_start();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("hold_req", imem_req, 1);
    reset_now();

    budget = 100;
    d0 = deliveries;
    pulse_start();
    for (int i = 0; i < 50 && deliveries == d0; i++) begin
      @(negedge clk);
      #1;
    end
    check("exec_delivered", 32'(deliveries > d0), 1);
    repeat (2) @(negedge clk);
    #1;
    check("exec_busy", busy, 1);
    check("exec_no_req", imem_req, 0);
    reset_now();

    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++)
        prog[i] = mk(legal_ops[$urandom_range(11, 0)], 1'($urandom_range(1, 0)),
                     3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 21'($urandom));
      budget = 40; fixed_delay = -1;
      run_prog();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
